// File: rtl/uart_baud_gen_frac.sv
// Fractional-N UART baud generator: os_tick every int+frac/2^FRAC_W clocks, bit_tick every OVERSAMPLE os_ticks.
// Tick outputs are decoded from registered counter state, gated by en/sync_clr in the same cycle.
module uart_baud_gen_frac #(
    parameter int INT_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int OVERSAMPLE   = 16,
    parameter int DEFAULT_INT  = 54,
    parameter int DEFAULT_FRAC = 4
) (
    input  logic                          clkin,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          sync_clr,
    input  logic [INT_W-1:0]              div_int,
    input  logic [FRAC_W-1:0]             div_frac,
    input  logic                          div_load,
    output logic                          div_busy,
    output logic                          os_tick,
    output logic                          bit_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] os_phase,
    output logic                          baud_out
);
    localparam int PH_W = $clog2(OVERSAMPLE);
    localparam int RST_EFF = (DEFAULT_INT < 2) ? 2 : DEFAULT_INT;
    localparam logic [INT_W:0]    RST_CNT   = (INT_W+1)'(RST_EFF - 1);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(OVERSAMPLE - 1);
    localparam logic [INT_W-1:0]  MIN_INT   = INT_W'(2);

    logic [INT_W-1:0]  act_int_q, act_int_d, pend_int_q, pend_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d, pend_frac_q, pend_frac_d;
    logic              busy_q, busy_d;
    logic [INT_W:0]    cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              baud_q, baud_d;

    logic              tick_raw, os_tick_c, bit_tick_c, phase_last, apply, restart;
    logic [INT_W-1:0]  eff_int;
    logic [FRAC_W:0]   acc_sum;

    always_comb begin
        tick_raw    = en && (cnt_q == '0);
        os_tick_c   = tick_raw && !sync_clr;
        phase_last  = (phase_q == PH_LAST);
        bit_tick_c  = os_tick_c && phase_last;
        // Apply is keyed to the ungated bit boundary so a coincident sync_clr still lets it land.
        apply       = busy_q && (!en || (tick_raw && phase_last));
        restart     = !en || sync_clr || apply;

        act_int_d   = apply ? pend_int_q  : act_int_q;
        act_frac_d  = apply ? pend_frac_q : act_frac_q;
        eff_int     = (act_int_d < MIN_INT) ? MIN_INT : act_int_d;
        acc_sum     = {1'b0, acc_q} + {1'b0, act_frac_q};

        pend_int_d  = pend_int_q;
        pend_frac_d = pend_frac_q;
        busy_d      = busy_q;
        if (apply)
            busy_d = 1'b0;
        if (div_load) begin
            pend_int_d  = div_int;
            pend_frac_d = div_frac;
            busy_d      = 1'b1;
        end

        cnt_d   = cnt_q;
        acc_d   = acc_q;
        phase_d = phase_q;
        if (restart) begin
            cnt_d   = {1'b0, eff_int} - (INT_W+1)'(1);
            acc_d   = '0;
            phase_d = '0;
        end else if (tick_raw) begin
            // Fractional carry stretches this os period by one clock.
            cnt_d   = {1'b0, eff_int} - (INT_W+1)'(1) + (INT_W+1)'(acc_sum[FRAC_W]);
            acc_d   = acc_sum[FRAC_W-1:0];
            phase_d = phase_last ? '0 : phase_q + PH_W'(1);
        end else begin
            cnt_d   = cnt_q - (INT_W+1)'(1);
        end

        baud_d = baud_q ^ bit_tick_c;
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            act_int_q   <= INT_W'(DEFAULT_INT);
            act_frac_q  <= FRAC_W'(DEFAULT_FRAC);
            pend_int_q  <= INT_W'(DEFAULT_INT);
            pend_frac_q <= FRAC_W'(DEFAULT_FRAC);
            busy_q      <= 1'b0;
            cnt_q       <= RST_CNT;
            acc_q       <= '0;
            phase_q     <= '0;
            baud_q      <= 1'b0;
        end else begin
            act_int_q   <= act_int_d;
            act_frac_q  <= act_frac_d;
            pend_int_q  <= pend_int_d;
            pend_frac_q <= pend_frac_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            phase_q     <= phase_d;
            baud_q      <= baud_d;
        end
    end

    assign os_tick  = os_tick_c;
    assign bit_tick = bit_tick_c;
    assign os_phase = phase_q;
    assign div_busy = busy_q;
    assign baud_out = baud_q;
endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Bench for uart_baud_gen_frac: closed-form tick-time model checked every cycle plus directed timing pins.
module tb_uart_baud_gen_frac;
    localparam int INT_W = 16, FRAC_W = 4, OS = 16;

    logic              clkin = 1'b0, rst = 1'b1, en = 1'b0, sync_clr = 1'b0, div_load = 1'b0;
    logic [INT_W-1:0]  div_int = '0;
    logic [FRAC_W-1:0] div_frac = '0;
    logic              div_busy, os_tick, bit_tick, baud_out;
    logic [3:0]        os_phase;

    int vecs = 0, errs = 0;

    uart_baud_gen_frac #(.INT_W(INT_W), .FRAC_W(FRAC_W), .OVERSAMPLE(OS),
                         .DEFAULT_INT(54), .DEFAULT_FRAC(4)) dut (
        .clkin(clkin), .rst(rst), .en(en), .sync_clr(sync_clr),
        .div_int(div_int), .div_frac(div_frac), .div_load(div_load),
        .div_busy(div_busy), .os_tick(os_tick), .bit_tick(bit_tick),
        .os_phase(os_phase), .baud_out(baud_out));

    always #5 clkin = ~clkin;

    task automatic chk(input string name, input longint act, input longint exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: after a restart, os tick number k (k=0,1,..) lands on enabled cycle
    // (k+1)*eff + floor(k*frac/2^FRAC_W); phase is simply k mod OS.
    longint m, k;
    int     act_i, act_f, pend_i, pend_f;
    bit     m_busy, m_baud;

    function automatic longint eff_of(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    function automatic bit raw_hit();
        longint target;
        target = (k + 1) * eff_of(act_i) + ((k * act_f) >> FRAC_W);
        return !rst && en && (m + 1 == target);
    endfunction

    always @(posedge clkin or posedge rst) begin
        bit hit, ost, bt, apply;
        if (rst) begin
            m = 0; k = 0; act_i = 54; act_f = 4; pend_i = 54; pend_f = 4;
            m_busy = 0; m_baud = 0;
        end else begin
            hit   = raw_hit();
            ost   = hit && !sync_clr;
            bt    = ost && (k % OS == OS - 1);
            apply = m_busy && (!en || (hit && (k % OS == OS - 1)));
            m_baud ^= bt;
            if (apply) begin act_i = pend_i; act_f = pend_f; m_busy = 0; end
            if (div_load) begin pend_i = int'(div_int); pend_f = int'(div_frac); m_busy = 1; end
            if (!en || sync_clr || apply) begin m = 0; k = 0; end
            else begin m++; if (ost) k++; end
        end
    end

    always @(negedge clkin) begin
        bit ost;
        ost = raw_hit() && !sync_clr;
        chk("os_tick",  os_tick,  ost);
        chk("bit_tick", bit_tick, ost && (k % OS == OS - 1));
        chk("os_phase", os_phase, k % OS);
        chk("div_busy", div_busy, m_busy);
        chk("baud_out", baud_out, m_baud);
    end

    task automatic os_gap(output int g);
        g = 0;
        do begin @(negedge clkin); g++; end while (!os_tick && g < 5000);
    endtask

    task automatic bit_gap(output int g);
        g = 0;
        do begin @(negedge clkin); g++; end while (!bit_tick && g < 20000);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    task automatic load(input int i, input int f);
        cyc(1);
        div_int = INT_W'(i); div_frac = FRAC_W'(f); div_load = 1'b1;
        cyc(1);
        div_load = 1'b0;
    endtask

    initial begin
        int g, n;
        int exp1 [8] = '{54, 54, 54, 55, 54, 54, 54, 55};
        // Reset defaults: 54 then 54,54,54,55 repeating
        cyc(3); rst = 0;
        cyc(1); en = 1;
        os_gap(g); chk("t1_first_os", g, 54);
        foreach (exp1[i]) begin os_gap(g); chk("t1_os_gap", g, exp1[i]); end
        cyc(1); rst = 1; en = 0;
        cyc(1); rst = 0; en = 1;
        bit_gap(g); chk("t1_bit_first", g, 867);
        bit_gap(g); chk("t1_bit_next", g, 868);

        // Divisor change mid-bit waits for the bit boundary
        cyc(100);
        load(27, 0);
        @(negedge clkin); chk("t2_busy_set", div_busy, 1);
        bit_gap(g); chk("t2_busy_at_apply", div_busy, 1);
        os_gap(g); chk("t2_os_27", g, 27);
        chk("t2_busy_clear", div_busy, 0);
        bit_gap(g); chk("t2_bit_rest", g, 405);
        bit_gap(g); chk("t2_bit_432", g, 432);

        // Clamp of divisor 1 and 0 to 2
        load(1, 0); bit_gap(g); bit_gap(g); chk("t3_bit_div1", g, 32);
        load(0, 0); bit_gap(g); bit_gap(g); chk("t3_bit_div0", g, 32);

        // sync_clr mid-period at phase 7
        load(54, 4); bit_gap(g);
        repeat (7) os_gap(g);
        cyc(20); sync_clr = 1;
        cyc(1);  sync_clr = 0;
        os_gap(g); chk("t4_os_after_sync", g, 54);
        @(negedge clkin); chk("t4_phase", os_phase, 1);
        n = 0;
        do begin os_gap(g); n++; end while (!bit_tick && n < 40);
        chk("t4_os_to_bit", n, 15);

        // Load while disabled applies on the next cycle
        cyc(1); en = 0;
        load(100, 8);
        @(negedge clkin); chk("t5_busy_1", div_busy, 1);
        @(negedge clkin); chk("t5_busy_0", div_busy, 0);
        cyc(5); en = 1;
        os_gap(g); chk("t5_first_os", g, 100);
        os_gap(g); chk("t5_os2", g, 100);
        os_gap(g); chk("t5_os3", g, 101);

        // Async reset with a pending load
        load(30, 0);
        repeat (200) @(posedge clkin);
        #3 rst = 1;
        #1;
        chk("t6_os_tick", os_tick, 0); chk("t6_bit_tick", bit_tick, 0);
        chk("t6_baud", baud_out, 0);   chk("t6_phase", os_phase, 0);
        chk("t6_busy", div_busy, 0);
        @(posedge clkin); #1 rst = 0;
        os_gap(g); chk("t6_first_os", g, 54);
        foreach (exp1[i]) begin os_gap(g); chk("t6_os_gap", g, exp1[i]); end

        // Randomized traffic against the model
        for (int c = 0; c < 30000; c++) begin
            cyc(1);
            en       = ($urandom_range(0, 59) != 0);
            sync_clr = ($urandom_range(0, 299) == 0);
            div_load = ($urandom_range(0, 399) == 0);
            div_int  = INT_W'($urandom_range(0, 20));
            div_frac = FRAC_W'($urandom_range(0, 15));
        end
        cyc(1); div_load = 0; sync_clr = 0;
        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errs);
        $fatal(1);
    end
endmodule
